gray_horiz_upsample: RTL and testbench

Horizontal 1:2 upsampler for 8-bit grayscale pixel streams: each input pixel produces two output pixels, the original followed by its linear midpoint with the next pixel in the same line. This is the inverse of the horizontal 2:1 downsample stage; it restores full line width before remap or display output. Because output rate is twice input rate, both sides use valid/ready handshakes.

---
 rtl/gray_horiz_upsample.sv | 162 ++++++++++++++++
 tb/tb_gray_horiz_upsample.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_horiz_upsample.sv
// gray_horiz_upsample
// Horizontal 1:2 upsampler for 8-bit grayscale lines. Every input pixel is
// emitted followed by the truncated midpoint between it and the next pixel
// of the same line; the last pixel of a line is emitted twice, so pixels
// are never blended across a line boundary.
//
// Ports
//   clk             clock, all state on rising edge
//   reset           asynchronous active-low reset
//   pixel_in        input pixel
//   pixel_in_valid  pixel_in is valid
//   pixel_in_ready  input accepted this cycle when valid & ready
//   pixel_out       output pixel (registered)
//   pixel_out_valid pixel_out is valid (registered)
//   pixel_out_ready downstream accepts pixel_out
//   pixel_out_eol   marks the last output pixel of a line (registered)
//
// State      | meaning
// EMPTY      | no pixel held; waiting for column pixel into cur
// WAIT_NEXT  | cur held; waiting for its right neighbour into nxt
// OUT_CUR    | presenting cur
// OUT_MID    | presenting midpoint(cur, nxt); may refill nxt in the same cycle
// LAST_A     | presenting last pixel of the line (first copy)
// LAST_B     | presenting last pixel again, with end-of-line flag
module gray_horiz_upsample #(
    parameter int LINE_WIDTH = 640
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pixel_in,
    input  logic       pixel_in_valid,
    output logic       pixel_in_ready,
    output logic [7:0] pixel_out,
    output logic       pixel_out_valid,
    input  logic       pixel_out_ready,
    output logic       pixel_out_eol
);

    localparam int CW = $clog2(LINE_WIDTH);
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);

    typedef enum logic [2:0] {
        EMPTY,
        WAIT_NEXT,
        OUT_CUR,
        OUT_MID,
        LAST_A,
        LAST_B
    } state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [7:0]    cur;
    logic [7:0]    nxt;
    logic          nxt_last;

    logic          in_fire;
    logic          out_fire;
    logic          col_at_last;
    logic [CW-1:0] col_next;

    function automatic logic [7:0] midpoint(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8:1];
    endfunction

    assign col_at_last = (col == COL_LAST);
    assign col_next    = col_at_last ? '0 : col + CW'(1);
    assign in_fire     = pixel_in_valid & pixel_in_ready;
    assign out_fire    = pixel_out_valid & pixel_out_ready;

    // Gated by reset so the block never advertises readiness while held in reset.
    // In OUT_MID a new neighbour can only be taken when the midpoint leaves in
    // the same cycle, and never once the line's last pixel is already held.
    always_comb begin
        pixel_in_ready = 1'b0;
        if (reset) begin
            case (state)
                EMPTY, WAIT_NEXT: pixel_in_ready = 1'b1;
                OUT_MID:          pixel_in_ready = pixel_out_ready & ~nxt_last;
                default:          pixel_in_ready = 1'b0;
            endcase
        end
    end

    // Outputs are loaded together with the state they belong to, so they are
    // plain flops and hold naturally while the downstream stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= EMPTY;
            col             <= '0;
            cur             <= '0;
            nxt             <= '0;
            nxt_last        <= 1'b0;
            pixel_out       <= '0;
            pixel_out_valid <= 1'b0;
            pixel_out_eol   <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        cur   <= pixel_in;
                        col   <= col_next;
                        state <= WAIT_NEXT;
                    end
                end
                WAIT_NEXT: begin
                    if (in_fire) begin
                        nxt             <= pixel_in;
                        nxt_last        <= col_at_last;
                        col             <= col_next;
                        pixel_out       <= cur;
                        pixel_out_valid <= 1'b1;
                        state           <= OUT_CUR;
                    end
                end
                OUT_CUR: begin
                    if (out_fire) begin
                        pixel_out <= midpoint(cur, nxt);
                        state     <= OUT_MID;
                    end
                end
                OUT_MID: begin
                    if (out_fire) begin
                        cur       <= nxt;
                        pixel_out <= nxt;
                        if (nxt_last) begin
                            state <= LAST_A;
                        end else if (in_fire) begin
                            nxt      <= pixel_in;
                            nxt_last <= col_at_last;
                            col      <= col_next;
                            state    <= OUT_CUR;
                        end else begin
                            pixel_out_valid <= 1'b0;
                            state           <= WAIT_NEXT;
                        end
                    end
                end
                LAST_A: begin
                    if (out_fire) begin
                        pixel_out_eol <= 1'b1;
                        state         <= LAST_B;
                    end
                end
                LAST_B: begin
                    if (out_fire) begin
                        nxt_last        <= 1'b0;
                        pixel_out_valid <= 1'b0;
                        pixel_out_eol   <= 1'b0;
                        state           <= EMPTY;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_horiz_upsample.sv
// Testbench for gray_horiz_upsample. Three instances (line widths 4, 2 and 8)
// share clock and reset. The width-4 instance is checked every cycle against
// a line-level model; the others are checked with directed expectations.
module tb_gray_horiz_upsample;

    typedef struct packed {
        logic [7:0] pix;
        logic       eol;
        logic       acc_ok;   // input may be taken while this pixel is presented
        logic       mid;
    } exp_t;
    typedef exp_t exp_q_t[$];
    typedef int   line_t[$];

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int ncyc = 0;

    // width-4 instance
    logic [7:0] a_in = '0;
    logic       a_in_valid = 1'b0;
    logic       a_in_ready;
    logic [7:0] a_out;
    logic       a_out_valid;
    logic       a_out_ready = 1'b0;
    logic       a_eol;
    // width-2 instance
    logic [7:0] b_in = '0;
    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic [7:0] b_out;
    logic       b_out_valid;
    logic       b_out_ready = 1'b0;
    logic       b_eol;
    // width-8 instance
    logic [7:0] c_in = '0;
    logic       c_in_valid = 1'b0;
    logic       c_in_ready;
    logic [7:0] c_out;
    logic       c_out_valid;
    logic       c_out_ready = 1'b0;
    logic       c_eol;

    gray_horiz_upsample #(.LINE_WIDTH(4)) dut_a (
        .clk(clk), .reset(reset),
        .pixel_in(a_in), .pixel_in_valid(a_in_valid), .pixel_in_ready(a_in_ready),
        .pixel_out(a_out), .pixel_out_valid(a_out_valid), .pixel_out_ready(a_out_ready),
        .pixel_out_eol(a_eol)
    );
    gray_horiz_upsample #(.LINE_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset),
        .pixel_in(b_in), .pixel_in_valid(b_in_valid), .pixel_in_ready(b_in_ready),
        .pixel_out(b_out), .pixel_out_valid(b_out_valid), .pixel_out_ready(b_out_ready),
        .pixel_out_eol(b_eol)
    );
    gray_horiz_upsample #(.LINE_WIDTH(8)) dut_c (
        .clk(clk), .reset(reset),
        .pixel_in(c_in), .pixel_in_valid(c_in_valid), .pixel_in_ready(c_in_ready),
        .pixel_out(c_out), .pixel_out_valid(c_out_valid), .pixel_out_ready(c_out_ready),
        .pixel_out_eol(c_eol)
    );

    // stimulus / model state
    int     a_drv[$];
    int     b_drv[$];
    int     c_drv[$];
    exp_t   exp_q[$];
    int     out_log[$];
    int     eol_log[$];
    int     b_log[$];
    int     b_eol_log[$];
    int     c_log[$];
    int     c_eol_log[$];
    int     c_vlog[$];
    int     c_irlog[$];
    logic   c_logging = 1'b0;
    logic   a_rnd_in = 1'b0;
    logic   a_rnd_out = 1'b0;
    logic   a_fire = 1'b0;
    logic   b_fire = 1'b0;
    logic   c_fire = 1'b0;
    logic   a_stall = 1'b0;
    logic   a_in_mid = 1'b0;
    logic [7:0] a_stall_pix = '0;
    logic   a_stall_eol = 1'b0;
    int     a_first_acc = -1;
    int     a_first_val = -1;
    exp_t   a_e;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic fail_now(input string name, input int act);
        checks++;
        $display("FAIL %s: got %0d, required completion", name, act);
    endtask

    // Expected output stream of one line, straight from the upsampling rule.
    function automatic exp_q_t model_line(input line_t p);
        exp_q_t q;
        exp_t   e;
        int     n;
        n = p.size();
        for (int i = 0; i < n; i++) begin
            e.pix = 8'(p[i]); e.eol = 1'b0; e.acc_ok = 1'b0; e.mid = 1'b0;
            q.push_back(e);
            if (i < n - 1) begin
                e.pix    = 8'((p[i] + p[i+1]) / 2);
                e.mid    = 1'b1;
                e.acc_ok = (i < n - 2);
                q.push_back(e);
            end else begin
                e.eol = 1'b1;
                q.push_back(e);
            end
        end
        return q;
    endfunction

    function automatic line_t mk4(input int p0, input int p1, input int p2, input int p3);
        line_t l;
        l.push_back(p0); l.push_back(p1); l.push_back(p2); l.push_back(p3);
        return l;
    endfunction

    task automatic add_a(input line_t l);
        exp_q_t q;
        foreach (l[i]) a_drv.push_back(l[i]);
        q = model_line(l);
        foreach (q[i]) exp_q.push_back(q[i]);
    endtask

    task automatic drain_a(input string name);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || a_drv.size() > 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) fail_now({name, "_timeout"}, exp_q.size());
        repeat (3) @(posedge clk);
    endtask

    task automatic check_seq8(input string name, input int lg[$], input int el[$], input int base,
                              input int e0, input int e1, input int e2, input int e3,
                              input int e4, input int e5, input int e6, input int e7,
                              input logic [7:0] eolm);
        int ex[8];
        ex = '{e0, e1, e2, e3, e4, e5, e6, e7};
        if (lg.size() < base + 8) begin
            fail_now({name, "_short"}, lg.size());
            return;
        end
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_pix%0d", name, i), lg[base+i], ex[i]);
            check($sformatf("%s_eol%0d", name, i), el[base+i], int'(eolm[i]));
        end
    endtask

    // Input driver: presents queued pixels just after each rising edge.
    initial begin : driver
        forever begin
            @(posedge clk);
            #1;
            if (a_fire && a_drv.size() > 0) void'(a_drv.pop_front());
            if (b_fire && b_drv.size() > 0) void'(b_drv.pop_front());
            if (c_fire && c_drv.size() > 0) void'(c_drv.pop_front());
            a_in_valid  = (a_drv.size() > 0) && (!a_rnd_in || $urandom_range(0, 1) == 1);
            a_in        = (a_drv.size() > 0) ? 8'(a_drv[0]) : 8'd0;
            a_out_ready = !a_rnd_out || $urandom_range(0, 1) == 1;
            b_in_valid  = (b_drv.size() > 0);
            b_in        = (b_drv.size() > 0) ? 8'(b_drv[0]) : 8'd0;
            b_out_ready = 1'b1;
            c_in_valid  = (c_drv.size() > 0);
            c_in        = (c_drv.size() > 0) ? 8'(c_drv[0]) : 8'd0;
            c_out_ready = 1'b1;
        end
    end

    // Compare process for the width-4 instance, sampled on the falling edge.
    initial begin : compare_a
        forever begin
            @(negedge clk);
            ncyc++;
            if (!reset) begin
                a_stall  = 1'b0;
                a_fire   = 1'b0;
                a_in_mid = 1'b0;
            end else begin
                a_fire = a_in_valid & a_in_ready;
                if (a_fire && a_first_acc < 0) a_first_acc = ncyc;
                if (a_out_valid && a_first_val < 0) a_first_val = ncyc;
                if (a_stall) begin
                    check("a_stall_valid", int'(a_out_valid), 1);
                    check("a_stall_pix", int'(a_out), int'(a_stall_pix));
                    check("a_stall_eol", int'(a_eol), int'(a_stall_eol));
                end
                a_in_mid = 1'b0;
                if (!a_out_valid) begin
                    check("a_idle_in_ready", int'(a_in_ready), 1);
                    check("a_idle_eol", int'(a_eol), 0);
                end else if (exp_q.size() == 0) begin
                    fail_now("a_unexpected_output", int'(a_out));
                end else begin
                    a_e = exp_q[0];
                    a_in_mid = a_e.mid;
                    check("a_in_ready", int'(a_in_ready), int'(a_e.acc_ok & a_out_ready));
                    if (a_out_ready) begin
                        check("a_pix", int'(a_out), int'(a_e.pix));
                        check("a_eol", int'(a_eol), int'(a_e.eol));
                        out_log.push_back(int'(a_out));
                        eol_log.push_back(int'(a_eol));
                        void'(exp_q.pop_front());
                    end
                end
                a_stall     = a_out_valid & ~a_out_ready;
                a_stall_pix = a_out;
                a_stall_eol = a_eol;
            end
        end
    end

    // Monitors for the width-2 and width-8 instances.
    initial begin : monitor_bc
        forever begin
            @(negedge clk);
            b_fire = reset & b_in_valid & b_in_ready;
            c_fire = reset & c_in_valid & c_in_ready;
            if (reset && b_out_valid && b_out_ready) begin
                b_log.push_back(int'(b_out));
                b_eol_log.push_back(int'(b_eol));
            end
            if (reset && c_out_valid && c_out_ready) begin
                c_log.push_back(int'(c_out));
                c_eol_log.push_back(int'(c_eol));
            end
            if (c_logging) begin
                c_vlog.push_back(int'(c_out_valid));
                c_irlog.push_back(int'(c_in_ready));
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        exp_q_t cq;
        line_t  l1;
        line_t  l2;
        int     n;
        int     run;
        int     gap;
        int     pos;
        int     runs[$];
        int     gaps[$];
        bit     seen;
        bit     found;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_valid", int'(a_out_valid), 0);
        check("rst_a_in_ready", int'(a_in_ready), 0);
        check("rst_a_pix", int'(a_out), 0);
        check("rst_a_eol", int'(a_eol), 0);
        check("rst_b_in_ready", int'(b_in_ready), 0);
        check("rst_c_in_ready", int'(c_in_ready), 0);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        // basic line, latency
        a_first_acc = -1;
        a_first_val = -1;
        add_a(mk4(10, 20, 30, 41));
        drain_a("s1");
        check("s1_latency", a_first_val - a_first_acc, 2);
        check("s1_len", out_log.size(), 8);
        check_seq8("s1", out_log, eol_log, 0, 10, 15, 20, 25, 30, 35, 41, 41, 8'h80);

        // random handshakes on both sides
        out_log.delete(); eol_log.delete();
        a_rnd_in = 1'b1; a_rnd_out = 1'b1;
        add_a(mk4(10, 20, 30, 41));
        drain_a("s3");
        a_rnd_in = 1'b0; a_rnd_out = 1'b0;
        check("s3_len", out_log.size(), 8);
        check_seq8("s3", out_log, eol_log, 0, 10, 15, 20, 25, 30, 35, 41, 41, 8'h80);

        // two lines back to back
        out_log.delete(); eol_log.delete();
        add_a(mk4(10, 20, 30, 41));
        add_a(mk4(100, 100, 0, 0));
        drain_a("s5");
        check("s5_len", out_log.size(), 16);
        check_seq8("s5_l1", out_log, eol_log, 0, 10, 15, 20, 25, 30, 35, 41, 41, 8'h80);
        check_seq8("s5_l2", out_log, eol_log, 8, 100, 100, 100, 50, 0, 0, 0, 0, 8'h80);

        // reset asserted while a midpoint is being presented
        add_a(mk4(10, 20, 30, 41));
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #1;
            if (a_in_mid) found = 1'b1;
        end
        if (!found) begin
            fail_now("s6_reach_mid_timeout", 0);
        end else begin
            check("s6_pre_valid", int'(a_out_valid), 1);
            reset = 1'b0;
            #1;
            check("s6_rst_valid", int'(a_out_valid), 0);
            check("s6_rst_in_ready", int'(a_in_ready), 0);
            check("s6_rst_pix", int'(a_out), 0);
            check("s6_rst_eol", int'(a_eol), 0);
        end
        reset = 1'b0;
        a_drv.delete(); exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        out_log.delete(); eol_log.delete();
        add_a(mk4(50, 61, 70, 90));
        drain_a("s6");
        check("s6_len", out_log.size(), 8);
        check_seq8("s6", out_log, eol_log, 0, 50, 55, 61, 65, 70, 80, 90, 90, 8'h80);

        // width 2: midpoint without overflow, minimal lines
        b_drv.push_back(255); b_drv.push_back(254);
        b_drv.push_back(0);   b_drv.push_back(1);
        n = 0;
        while (b_log.size() < 8 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) fail_now("s2_timeout", b_log.size());
        repeat (3) @(posedge clk);
        check("s2_len", b_log.size(), 8);
        check_seq8("s2", b_log, b_eol_log, 0, 255, 254, 254, 254, 0, 0, 1, 1, 8'h88);

        // width 8: continuous flow, throughput and gap between lines
        for (int i = 0; i < 8; i++) begin
            l1.push_back(i * 30 + 5);
            l2.push_back(250 - i * 33);
        end
        c_logging = 1'b1;
        foreach (l1[i]) c_drv.push_back(l1[i]);
        foreach (l2[i]) c_drv.push_back(l2[i]);
        n = 0;
        while (c_log.size() < 32 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) fail_now("s4_timeout", c_log.size());
        repeat (4) @(posedge clk);
        c_logging = 1'b0;

        cq = model_line(l1);
        begin
            exp_q_t cq2;
            cq2 = model_line(l2);
            foreach (cq2[i]) cq.push_back(cq2[i]);
        end
        check("s4_len", c_log.size(), 32);
        for (int i = 0; i < 32 && i < c_log.size(); i++) begin
            check($sformatf("s4_pix%0d", i), c_log[i], int'(cq[i].pix));
            check($sformatf("s4_eol%0d", i), c_eol_log[i], int'(cq[i].eol));
        end

        run = 0; gap = 0; seen = 1'b0; pos = 0;
        foreach (c_vlog[i]) begin
            if (c_vlog[i] != 0) begin
                if (seen && gap > 0) gaps.push_back(gap);
                gap = 0;
                run++;
                seen = 1'b1;
                check($sformatf("s4_in_ready_pos%0d", pos), c_irlog[i],
                      ((pos % 2 == 1) && (pos < 13)) ? 1 : 0);
                pos++;
            end else begin
                if (run > 0) runs.push_back(run);
                run = 0;
                pos = 0;
                if (seen) gap++;
                check("s4_idle_in_ready", c_irlog[i], 1);
            end
        end
        if (run > 0) runs.push_back(run);
        check("s4_run_count", runs.size(), 2);
        if (runs.size() >= 2) begin
            check("s4_run0", runs[0], 16);
            check("s4_run1", runs[1], 16);
        end
        check("s4_gap_count", gaps.size(), 1);
        if (gaps.size() >= 1) check("s4_gap", gaps[0], 2);

        check("final_a_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
